// File: rtl/regfile_dump_sequencer_if.sv
// Handshake/bus bundle between the dump sequencer, the register file read ports and the word consumer.
// Latency: none (wires only).
// Backpressure: carried by out_valid/out_ready; the master holds a word until it is accepted.
interface regfile_dump_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] read_register1;
  logic [ADDR_W-1:0] read_register2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_reg;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  // Sequencer side
  modport master (
    input  start, first_reg, last_reg, read_data1, read_data2, out_ready,
    output read_register1, read_register2, out_valid, out_reg, out_data,
           busy, done, checksum
  );

  // Requester / register file / consumer side
  modport slave (
    output start, first_reg, last_reg, read_data1, read_data2, out_ready,
    input  read_register1, read_register2, out_valid, out_reg, out_data,
           busy, done, checksum
  );
endinterface

// File: rtl/regfile_dump_sequencer.sv
// Walks a register range two at a time on the file's two read ports and streams each value with a running checksum.
// Latency: Start edge to first word valid = 2 cycles; 3 cycles per register pair with the consumer always ready.
// Backpressure: a word is held stable on out_valid until out_ready accepts it; no reads are issued while stalled.
module regfile_dump_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                     i_clk,
  input logic                     i_rst,
  regfile_dump_sequencer_if.master io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EMIT_A,
    S_EMIT_B,
    S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_last;
  logic [DATA_W-1:0] r_hold_a;
  logic [DATA_W-1:0] r_hold_b;
  logic [DATA_W-1:0] r_checksum;
  logic [ADDR_W-1:0] r_rd1;
  logic [ADDR_W-1:0] r_rd2;

  logic [ADDR_W-1:0] w_cur_p1;
  logic              w_accept;
  logic              w_out_valid;
  logic [ADDR_W-1:0] w_out_reg;
  logic [DATA_W-1:0] w_out_data;
  logic              w_busy;
  logic              w_done;

  // cur+1 wraps at 5 bits; the last-register compare stops the walk before a wrapped index is emitted
  assign w_cur_p1 = r_cur + ADDR_W'(1);
  assign w_accept = w_out_valid & io_bus.out_ready;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next_state = r_state;
    w_out_valid  = 1'b0;
    w_out_reg    = '0;
    w_out_data   = '0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_next_state = (io_bus.first_reg <= io_bus.last_reg) ? S_READ : S_FINISH;
        end
      end
      S_READ: begin
        w_busy       = 1'b1;
        w_next_state = S_EMIT_A;
      end
      S_EMIT_A: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_out_reg   = r_cur;
        w_out_data  = r_hold_a;
        if (w_accept) w_next_state = (r_cur == r_last) ? S_FINISH : S_EMIT_B;
      end
      S_EMIT_B: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_out_reg   = w_cur_p1;
        w_out_data  = r_hold_b;
        if (w_accept) w_next_state = (w_cur_p1 == r_last) ? S_FINISH : S_READ;
      end
      S_FINISH: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: range latch, read addresses (loaded on entry to READ), hold registers, checksum
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur      <= '0;
      r_last     <= '0;
      r_hold_a   <= '0;
      r_hold_b   <= '0;
      r_checksum <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_cur      <= io_bus.first_reg;
            r_last     <= io_bus.last_reg;
            r_checksum <= '0;
            if (io_bus.first_reg <= io_bus.last_reg) begin
              r_rd1 <= io_bus.first_reg;
              r_rd2 <= io_bus.first_reg + ADDR_W'(1);
            end
          end
        end
        S_READ: begin
          r_hold_a <= io_bus.read_data1;
          r_hold_b <= io_bus.read_data2;
        end
        S_EMIT_A: begin
          if (w_accept) r_checksum <= r_checksum + r_hold_a;
        end
        S_EMIT_B: begin
          if (w_accept) begin
            r_checksum <= r_checksum + r_hold_b;
            if (w_cur_p1 != r_last) begin
              r_cur <= r_cur + ADDR_W'(2);
              r_rd1 <= r_cur + ADDR_W'(2);
              r_rd2 <= r_cur + ADDR_W'(3);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.read_register1 = r_rd1;
  assign io_bus.read_register2 = r_rd2;
  assign io_bus.out_valid      = w_out_valid;
  assign io_bus.out_reg        = w_out_reg;
  assign io_bus.out_data       = w_out_data;
  assign io_bus.busy           = w_busy;
  assign io_bus.done           = w_done;
  assign io_bus.checksum       = r_checksum;

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Directed bench for regfile_dump_sequencer: register file model preloaded with 5*i, hand-computed words and checksums.
// Latency: outputs sampled on the falling edge; inputs driven on the falling edge.
// Backpressure: out_ready either held high or toggled 0,0,1.
module tb_regfile_dump_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_dump_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_dump_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  logic [DATA_W-1:0] mem [32];
  assign bus.read_data1 = mem[bus.read_register1];
  assign bus.read_data2 = mem[bus.read_register2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One dump f..l. bp toggles ready 0,0,1; restart pulses Start mid-dump; rst_after>0 resets after that many accepted words.
  // exp_done is the cycle (1 = first cycle after the Start sampling edge) in which Done is high; -1 skips that check.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit bp, input bit restart,
                          input int rst_after, input int exp_words, input logic [31:0] exp_sum,
                          input int exp_done);
    int          nwords;
    int          done_cyc;
    int          phase;
    logic [4:0]  exp_reg;
    bit          pend;
    bit          seen_valid;
    logic [4:0]  p_reg;
    logic [31:0] p_dat;
    nwords = 0; done_cyc = -1; phase = 0; pend = 1'b0; seen_valid = 1'b0;
    p_reg = '0; p_dat = '0; exp_reg = f;

    @(negedge clk);
    bus.first_reg = f;
    bus.last_reg  = l;
    bus.start     = 1'b1;
    bus.out_ready = !bp;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.first_reg = 5'd0;   // changes after the latch must be ignored
    bus.last_reg  = 5'd1;
    chk("busy_after_start", bus.busy, (exp_words > 0) ? 32'd1 : 32'd0);

    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (bp) begin
        bus.out_ready = (phase % 3 == 2);
        phase++;
      end
      if (restart) bus.start = (cyc == 10);
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.out_valid) begin
        seen_valid = 1'b1;
        if (pend) begin
          chk("hold_reg", bus.out_reg, p_reg);
          chk("hold_dat", bus.out_data, p_dat);
        end
        if (bus.out_ready) begin
          chk("word_reg", bus.out_reg, exp_reg);
          chk("word_dat", bus.out_data, {27'd0, exp_reg} * 32'd5);
          exp_reg++;
          nwords++;
          pend = 1'b0;
        end else begin
          pend  = 1'b1;
          p_reg = bus.out_reg;
          p_dat = bus.out_data;
        end
      end
      if (rst_after > 0 && nwords == rst_after) begin
        bus.start = 1'b0;
        @(posedge clk);   // this edge accepts the word
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_checksum", bus.checksum, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out_dat", bus.out_data, 0);
        @(negedge clk);
        chk("rst_done_hold", bus.done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", bus.done, 0);
        chk("post_rst_busy", bus.busy, 0);
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;

    chk("done_seen", (done_cyc >= 0), 1);
    chk("word_count", nwords, exp_words);
    chk("checksum", bus.checksum, exp_sum);
    chk("busy_at_done", bus.busy, 0);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    if (exp_words == 0) chk("no_valid", seen_valid, 0);
    @(negedge clk);
    chk("done_one_pulse", bus.done, 0);
    chk("checksum_hold", bus.checksum, exp_sum);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(i) * 32'd5;
    bus.start     = 1'b0;
    bus.first_reg = '0;
    bus.last_reg  = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_checksum", bus.checksum, 0);
    chk("reset_rr1", bus.read_register1, 0);
    chk("reset_rr2", bus.read_register2, 0);
    chk("reset_out_reg", bus.out_reg, 0);
    chk("reset_out_dat", bus.out_data, 0);

    // 18 words 40..125, sum 5*(8+..+25)=1485; Done in the 29th cycle counting the Start cycle
    run_dump(5'd8,  5'd25, 1'b0, 1'b0, 0, 18, 32'd1485, 28);
    // odd range: 5 words, sum 250, register 13 never emitted
    run_dump(5'd8,  5'd12, 1'b0, 1'b0, 0, 5,  32'd250,  9);
    // backpressure: 4 words, sum 190
    run_dump(5'd8,  5'd11, 1'b1, 1'b0, 0, 4,  32'd190,  -1);
    // empty range: no words, Done right after the Start cycle
    run_dump(5'd20, 5'd10, 1'b0, 1'b0, 0, 0,  32'd0,    1);
    // Start pulsed mid-dump is ignored
    run_dump(5'd8,  5'd25, 1'b0, 1'b1, 0, 18, 32'd1485, 28);
    // ranges ending at 31: no index wrap
    run_dump(5'd28, 5'd31, 1'b0, 1'b0, 0, 4,  32'd590,  7);
    run_dump(5'd31, 5'd31, 1'b0, 1'b0, 0, 1,  32'd155,  3);
    // reset after the 3rd accepted word, then a fresh 8..9 dump
    run_dump(5'd8,  5'd25, 1'b0, 1'b0, 3, 18, 32'd1485, -1);
    run_dump(5'd8,  5'd9,  1'b0, 1'b0, 0, 2,  32'd85,   4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
